// File: rtl/mem_ctrl.sv
// Byte-wide RAM arbiter: the MEM stage has absolute priority, and an
// instruction-fetch engine assembles 32-bit words from four byte reads.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_rw_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  mem_data_o,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] base_r;
  logic [1:0]  issue_cnt;
  logic [1:0]  recv_cnt;
  logic        pend;
  logic [7:0]  b0_r;
  logic [7:0]  b1_r;
  logic [7:0]  b2_r;
  logic [31:0] if_inst_r;
  logic        if_valid_r;

  logic mem_act_s;
  logic accept_s;
  logic all_issued_s;
  logic issue_s;
  logic capture_s;
  logic done_s;

  assign mem_data_o = ram_din_i;
  assign if_inst_o  = if_inst_r;
  assign if_valid_o = if_valid_r;

  // Request decode; four bytes are out once byte 3 is in flight (pend with recv_cnt at 3)
  always_comb begin
    mem_act_s    = (mem_rw_i == 2'b01) || (mem_rw_i == 2'b10);
    accept_s     = (state_r == IDLE) && if_req_i && !if_flush_i;
    all_issued_s = pend && (recv_cnt == 2'd3);
    issue_s      = (state_r == FETCH) && !mem_act_s && !all_issued_s;
    capture_s    = pend && !if_flush_i;
    done_s       = capture_s && (recv_cnt == 2'd3);
  end

  // Next-state logic; flush overrides both accept and completion
  always_comb begin
    state_s = state_r;
    if (if_flush_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_s = FETCH;
          else          state_s = IDLE;
        end
        FETCH: begin
          if (done_s) state_s = IDLE;
          else        state_s = FETCH;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // RAM port mux: reset forces an idle bus, then MEM, then fetch issue
  always_comb begin
    ram_a_o    = 32'd0;
    ram_wr_o   = 1'b0;
    ram_dout_o = 8'd0;
    if (rst) begin
      ram_a_o    = 32'd0;
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'd0;
    end else if (mem_act_s) begin
      ram_a_o    = mem_addr_i;
      ram_wr_o   = (mem_rw_i == 2'b10);
      ram_dout_o = mem_data_i;
    end else if (issue_s) begin
      ram_a_o    = base_r + {30'd0, issue_cnt};
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'd0;
    end else begin
      ram_a_o    = 32'd0;
      ram_wr_o   = 1'b0;
      ram_dout_o = 8'd0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Fetch datapath: base, counters, byte lanes and the output word
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r     <= 32'd0;
      issue_cnt  <= 2'd0;
      recv_cnt   <= 2'd0;
      pend       <= 1'b0;
      b0_r       <= 8'd0;
      b1_r       <= 8'd0;
      b2_r       <= 8'd0;
      if_inst_r  <= 32'd0;
      if_valid_r <= 1'b0;
    end else begin
      if_valid_r <= 1'b0;
      pend       <= issue_s && !if_flush_i;
      if (if_flush_i) begin
        issue_cnt <= 2'd0;
        recv_cnt  <= 2'd0;
      end else if (accept_s) begin
        base_r    <= if_addr_i;
        issue_cnt <= 2'd0;
        recv_cnt  <= 2'd0;
      end else begin
        if (issue_s) issue_cnt <= issue_cnt + 2'd1;
        if (capture_s) begin
          recv_cnt <= recv_cnt + 2'd1;
          case (recv_cnt)
            2'd0:    b0_r <= ram_din_i;
            2'd1:    b1_r <= ram_din_i;
            2'd2:    b2_r <= ram_din_i;
            default: b2_r <= b2_r;
          endcase
        end
        // Byte 3 goes straight from the RAM into the output word
        if (done_s) begin
          if_inst_r  <= {ram_din_i, b2_r, b1_r, b0_r};
          if_valid_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: the driver pushes expected RAM-bus, read-data
// and instruction records per cycle; a negedge monitor pops and compares them.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_rw_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_inst_o;
  logic        if_valid_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } ram_rec_t;

  typedef struct {
    int          cyc;
    logic [31:0] v;
  } exp_t;

  ram_rec_t ram_q[$];
  exp_t     rd_q[$];
  exp_t     fq[$];

  logic [7:0]  ram_mem [logic [31:0]];
  logic [7:0]  shadow  [logic [31:0]];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] hold_inst = 32'd0;
  ram_rec_t    mon_r;
  exp_t        mon_e;

  mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rw_i   (mem_rw_i),
    .mem_addr_i (mem_addr_i),
    .mem_data_i (mem_data_i),
    .mem_data_o (mem_data_o),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_flush_i (if_flush_i),
    .if_inst_o  (if_inst_o),
    .if_valid_o (if_valid_o),
    .ram_a_o    (ram_a_o),
    .ram_wr_o   (ram_wr_o),
    .ram_dout_o (ram_dout_o),
    .ram_din_i  (ram_din_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_byte(a);
  endfunction

  // Synchronous RAM environment: read data appears one cycle after the address
  always @(posedge clk) begin
    if (ram_mem.exists(ram_a_o)) ram_din_i <= ram_mem[ram_a_o];
    else                         ram_din_i <= init_byte(ram_a_o);
    if (ram_wr_o) ram_mem[ram_a_o] = ram_dout_o;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) hold_inst = 32'd0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compare whatever the scoreboard expects for this cycle
  always @(negedge clk) begin
    if (ram_q.size() > 0 && ram_q[0].cyc == cyc) begin
      mon_r = ram_q.pop_front();
      chk("ram_a", ram_a_o, mon_r.a);
      chk("ram_wr", {31'd0, ram_wr_o}, {31'd0, mon_r.wr});
      chk("ram_dout", {24'd0, ram_dout_o}, {24'd0, mon_r.d});
    end
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
      mon_e = rd_q.pop_front();
      chk("mem_data", {24'd0, mem_data_o}, mon_e.v);
    end
    if (fq.size() > 0 && fq[0].cyc == cyc) begin
      mon_e = fq.pop_front();
      chk("if_valid", {31'd0, if_valid_o}, 32'd1);
      chk("if_inst", if_inst_o, mon_e.v);
      hold_inst = mon_e.v;
    end else begin
      chk("if_valid_quiet", {31'd0, if_valid_o}, 32'd0);
      chk("if_inst_hold", if_inst_o, hold_inst);
    end
  end

  // One cycle of stimulus plus the expected RAM bus for that cycle
  task automatic step(input logic req, input logic [31:0] ia, input logic fl, input logic rs,
                      input logic [1:0] rw, input logic [31:0] ma, input logic [7:0] md,
                      input logic iss, input logic [31:0] fa, output int cn);
    ram_rec_t r;
    @(posedge clk);
    #1;
    rst        = rs;
    if_req_i   = req;
    if_addr_i  = ia;
    if_flush_i = fl;
    mem_rw_i   = rw;
    mem_addr_i = ma;
    mem_data_i = md;
    cn   = cyc;
    r.cyc = cyc;
    r.a   = 32'd0;
    r.wr  = 1'b0;
    r.d   = 8'd0;
    if (!rs) begin
      if (rw == 2'b01 || rw == 2'b10) begin
        r.a  = ma;
        r.wr = (rw == 2'b10);
        r.d  = md;
        if (rw == 2'b01) rd_q.push_back('{cyc + 1, {24'd0, sh_rd(ma)}});
        else             shadow[ma] = md;
      end else if (iss) begin
        r.a = fa;
      end
    end
    ram_q.push_back(r);
  endtask

  task automatic rand_mem(input int pct, output logic [1:0] rw, output logic [31:0] ma,
                          output logic [7:0] md);
    rw = 2'b00;
    ma = 32'd0;
    md = 8'd0;
    if (int'($urandom_range(99)) < pct) begin
      rw = 2'($urandom_range(3));
      ma = 32'h3000_0000 | $urandom_range(63);
      md = 8'($urandom_range(255));
    end
  endtask

  task automatic idle_cycle(input int pct);
    logic [1:0]  rw;
    logic [31:0] ma;
    logic [7:0]  md;
    int          cn;
    rand_mem(pct, rw, ma, md);
    step(1'b0, $urandom(), 1'b0, 1'b0, rw, ma, md, 1'b0, 32'd0, cn);
  endtask

  // One fetch: the model counts free MEM cycles to place each issue and the strobe
  task automatic do_fetch(input logic [31:0] base, input int flush_at, input int rst_at,
                          input int pct, input int fc, input logic [1:0] frw,
                          input logic [31:0] fa, input logic [7:0] fd,
                          input bit use_exp, input logic [31:0] exp_inst);
    int          k;
    int          cn;
    logic [1:0]  rw;
    logic [31:0] ma;
    logic [7:0]  md;
    logic [31:0] inst;
    logic        fl;
    logic        rs;
    logic        mact;
    logic        rq;
    k = 0;
    if (use_exp) inst = exp_inst;
    else inst = {sh_rd(base + 32'd3), sh_rd(base + 32'd2), sh_rd(base + 32'd1), sh_rd(base)};
    step(1'b1, base, 1'b0, 1'b0, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0, cn);
    for (int c = 1; c < 64; c++) begin
      if (c == fc) begin
        rw = frw;
        ma = fa;
        md = fd;
      end else begin
        rand_mem((c < 20) ? pct : 0, rw, ma, md);
      end
      fl   = (c == flush_at);
      rs   = (c == rst_at);
      rq   = 1'($urandom_range(1));
      mact = (rw == 2'b01) || (rw == 2'b10);
      if (fl || rs) begin
        step(rq, $urandom(), fl, rs, rw, ma, md, !mact && (k < 4), base + 32'(k), cn);
        break;
      end else if (k == 4) begin
        step(rq, $urandom(), 1'b0, 1'b0, rw, ma, md, 1'b0, 32'd0, cn);
        fq.push_back('{cn + 1, inst});
        break;
      end else if (mact) begin
        step(rq, $urandom(), 1'b0, 1'b0, rw, ma, md, 1'b0, 32'd0, cn);
      end else begin
        step(rq, $urandom(), 1'b0, 1'b0, rw, ma, md, 1'b1, base + 32'(k), cn);
        k = k + 1;
      end
    end
  endtask

  initial begin
    int          cn;
    logic [31:0] base;
    rst        = 1'b1;
    mem_rw_i   = 2'b00;
    mem_addr_i = 32'd0;
    mem_data_i = 8'd0;
    if_req_i   = 1'b0;
    if_addr_i  = 32'd0;
    if_flush_i = 1'b0;
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'b10, 32'h44, 8'h11, 1'b0, 32'd0, cn);
    step(1'b0, 32'd0, 1'b0, 1'b1, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0, cn);

    // Byte write then read-back
    step(1'b0, 32'd0, 1'b0, 1'b0, 2'b10, 32'h30, 8'hAB, 1'b0, 32'd0, cn);
    step(1'b0, 32'd0, 1'b0, 1'b0, 2'b01, 32'h30, 8'h00, 1'b0, 32'd0, cn);
    step(1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0, cn);

    ram_mem[32'h100] = 8'h13; shadow[32'h100] = 8'h13;
    ram_mem[32'h101] = 8'h05; shadow[32'h101] = 8'h05;
    ram_mem[32'h102] = 8'h10; shadow[32'h102] = 8'h10;
    ram_mem[32'h103] = 8'h00; shadow[32'h103] = 8'h00;

    // Conflict-free fetch, then the same fetch with a MEM read in cycle 2
    do_fetch(32'h100, -1, -1, 0, -1, 2'b00, 32'd0, 8'd0, 1'b1, 32'h00100513);
    idle_cycle(0);
    do_fetch(32'h100, -1, -1, 0, 2, 2'b01, 32'h2000, 8'd0, 1'b1, 32'h00100513);

    // Flush in cycle 3 then an immediate new request; address wrap; reset mid-fetch
    do_fetch(32'h100, 3, -1, 0, -1, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0);
    do_fetch(32'h200, -1, -1, 0, -1, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0);
    do_fetch(32'hFFFF_FFFE, -1, -1, 0, -1, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0);
    do_fetch(32'h100, -1, 3, 0, 3, 2'b10, 32'h3000_0010, 8'h77, 1'b0, 32'd0);
    idle_cycle(0);

    for (int i = 0; i < 120; i++) begin
      for (int g = 0; g < int'($urandom_range(2)); g++) idle_cycle(50);
      if ($urandom_range(3) == 0) base = 32'hFFFF_FFFC + $urandom_range(3);
      else                        base = 32'h0000_1000 + $urandom_range(4095);
      do_fetch(base,
               ($urandom_range(9) == 0) ? int'($urandom_range(10, 1)) : -1,
               ($urandom_range(19) == 0) ? int'($urandom_range(8, 1)) : -1,
               35, -1, 2'b00, 32'd0, 8'd0, 1'b0, 32'd0);
    end
    for (int i = 0; i < 4; i++) idle_cycle(0);

    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
